// File: rtl/ata_disk_model.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ata_disk_model : behavioural ATA/IDE drive with task file, multi-sector
//                  READ/WRITE SECTORS, LBA28 range checking and flush.
// Revision: 1.0  initial multi-sector model
// ----------------------------------------------------------------------------
module ata_disk_model #(
    parameter int DATA_W       = 8,
    parameter int SECTOR_BYTES = 512,
    parameter int NUM_SECTORS  = 2048,
    parameter int BUSY_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq,
    output logic              busy
);
    localparam int c_bpw       = DATA_W / 8;
    localparam int c_words     = SECTOR_BYTES / c_bpw;
    localparam int c_ptr_w     = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int c_mem_bytes = SECTOR_BYTES * NUM_SECTORS;
    localparam int c_aw        = $clog2(c_mem_bytes);
    localparam int c_sb_w      = $clog2(SECTOR_BYTES);
    localparam int c_cnt_w     = $clog2(BUSY_CYCLES + 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_rd_busy   = 3'd1;
    localparam logic [2:0] c_st_rd_xfer   = 3'd2;
    localparam logic [2:0] c_st_wr_xfer   = 3'd3;
    localparam logic [2:0] c_st_wr_commit = 3'd4;
    localparam logic [2:0] c_st_flush     = 3'd5;

    localparam logic [c_cnt_w-1:0] c_busy_reload = c_cnt_w'(BUSY_CYCLES - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last    = c_ptr_w'(c_words - 1);

    logic [7:0] r_mem  [c_mem_bytes];
    logic [7:0] r_sbuf [SECTOR_BYTES];

    logic [2:0]         r_state,   w_state_n;
    logic [c_cnt_w-1:0] r_cnt,     w_cnt_n;
    logic [c_ptr_w-1:0] r_ptr,     w_ptr_n;
    logic [8:0]         r_rem,     w_rem_n;
    logic [27:0]        r_lba_cur, w_lba_cur_n;
    logic               r_irq,     w_irq_n;
    logic               r_err,     w_err_n;
    logic [7:0]         r_error,   w_error_n;
    logic [7:0]         r_count,   w_count_n;
    logic [7:0]         r_lba0,    w_lba0_n;
    logic [7:0]         r_lba1,    w_lba1_n;
    logic [7:0]         r_lba2,    w_lba2_n;
    logic [7:0]         r_dev,     w_dev_n;
    logic               r_rd_q, r_wr_q;
    logic [2:0]         r_rd_addr;

    logic              w_rd_acc, w_wr_acc, w_wr_evt, w_rd_evt;
    logic              w_bsy, w_drq, w_range_bad, w_commit, w_buf_wr;
    logic [7:0]        w_status;
    logic [27:0]       w_lba;
    logic [8:0]        w_count9;
    logic [c_aw-1:0]   w_base, w_word_addr;
    logic [DATA_W-1:0] w_word, w_reg;

    assign w_rd_acc = !cs_n && !rd_n && wr_n;
    assign w_wr_acc = !cs_n && !wr_n;
    assign w_wr_evt = w_wr_acc && !r_wr_q;
    assign w_rd_evt = !w_rd_acc && r_rd_q;

    assign w_bsy    = (r_state == c_st_rd_busy) || (r_state == c_st_wr_commit) ||
                      (r_state == c_st_flush);
    assign w_drq    = (r_state == c_st_rd_xfer) || (r_state == c_st_wr_xfer);
    assign w_status = {w_bsy, 1'b1, 2'b00, w_drq, 2'b00, r_err};

    assign w_lba       = {r_dev[3:0], r_lba2, r_lba1, r_lba0};
    assign w_count9    = (r_count == 8'd0) ? 9'd256 : {1'b0, r_count};
    assign w_range_bad = ({4'b0000, w_lba} + 32'(w_count9)) > 32'(NUM_SECTORS);

    assign w_base      = c_aw'(r_lba_cur * SECTOR_BYTES);
    assign w_word_addr = w_base + c_aw'(r_ptr * c_bpw);
    assign w_commit    = (r_state == c_st_wr_commit) && (r_cnt == '0);
    assign w_buf_wr    = (r_state == c_st_wr_xfer) && w_wr_evt && (addr == 3'd0);

    // Little-endian assembly: byte b of the word comes from the b-th address.
    always_comb begin
        w_word = '0;
        for (int b = 0; b < c_bpw; b++) begin
            w_word[b*8 +: 8] = r_mem[w_word_addr + c_aw'(b)];
        end
    end

    always_comb begin
        w_reg = '0;
        case (addr)
            3'd0:    w_reg = (r_state == c_st_rd_xfer) ? w_word : '0;
            3'd1:    w_reg = DATA_W'(r_error);
            3'd2:    w_reg = DATA_W'(r_count);
            3'd3:    w_reg = DATA_W'(r_lba0);
            3'd4:    w_reg = DATA_W'(r_lba1);
            3'd5:    w_reg = DATA_W'(r_lba2);
            3'd6:    w_reg = DATA_W'(r_dev);
            default: w_reg = DATA_W'(w_status);
        endcase
    end

    assign data_out = w_rd_acc ? w_reg : 'z;
    assign irq      = r_irq;
    assign busy     = w_bsy;

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_ptr_n     = r_ptr;
        w_rem_n     = r_rem;
        w_lba_cur_n = r_lba_cur;
        w_irq_n     = r_irq;
        w_err_n     = r_err;
        w_error_n   = r_error;
        w_count_n   = r_count;
        w_lba0_n    = r_lba0;
        w_lba1_n    = r_lba1;
        w_lba2_n    = r_lba2;
        w_dev_n     = r_dev;

        // Clears come first so that any set later in this block wins.
        if (w_rd_evt && (r_rd_addr == 3'd7)) begin
            w_irq_n = 1'b0;
        end

        if (w_wr_evt && !w_bsy) begin
            case (addr)
                3'd2:    w_count_n = data_in[7:0];
                3'd3:    w_lba0_n  = data_in[7:0];
                3'd4:    w_lba1_n  = data_in[7:0];
                3'd5:    w_lba2_n  = data_in[7:0];
                3'd6:    w_dev_n   = data_in[7:0];
                default: ;
            endcase
        end

        case (r_state)
            c_st_idle: begin
                if (w_wr_evt && (addr == 3'd7)) begin
                    w_err_n   = 1'b0;
                    w_error_n = 8'h00;
                    w_irq_n   = 1'b0;
                    case (data_in[7:0])
                        8'h20, 8'h30: begin
                            if (w_range_bad) begin
                                w_err_n   = 1'b1;
                                w_error_n = 8'h10;
                                w_irq_n   = 1'b1;
                            end else begin
                                w_lba_cur_n = w_lba;
                                w_rem_n     = w_count9;
                                w_ptr_n     = '0;
                                if (data_in[7:0] == 8'h20) begin
                                    w_state_n = c_st_rd_busy;
                                    w_cnt_n   = c_busy_reload;
                                end else begin
                                    w_state_n = c_st_wr_xfer;
                                end
                            end
                        end
                        8'hE7: begin
                            w_state_n = c_st_flush;
                            w_cnt_n   = c_busy_reload;
                        end
                        default: begin
                            w_err_n   = 1'b1;
                            w_error_n = 8'h04;
                            w_irq_n   = 1'b1;
                        end
                    endcase
                end
            end
            c_st_rd_busy, c_st_wr_commit, c_st_flush: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - 1'b1;
                end else begin
                    w_irq_n = 1'b1;
                    if (r_state == c_st_rd_busy) begin
                        w_state_n = c_st_rd_xfer;
                        w_ptr_n   = '0;
                    end else if (r_state == c_st_wr_commit) begin
                        w_rem_n     = r_rem - 9'd1;
                        w_lba_cur_n = r_lba_cur + 28'd1;
                        w_ptr_n     = '0;
                        w_state_n   = (r_rem == 9'd1) ? c_st_idle : c_st_wr_xfer;
                    end else begin
                        w_state_n = c_st_idle;
                    end
                end
            end
            c_st_rd_xfer: begin
                if (w_rd_evt && (r_rd_addr == 3'd0)) begin
                    if (r_ptr == c_ptr_last) begin
                        w_ptr_n     = '0;
                        w_rem_n     = r_rem - 9'd1;
                        w_lba_cur_n = r_lba_cur + 28'd1;
                        if (r_rem == 9'd1) begin
                            w_state_n = c_st_idle;
                        end else begin
                            w_state_n = c_st_rd_busy;
                            w_cnt_n   = c_busy_reload;
                        end
                    end else begin
                        w_ptr_n = r_ptr + 1'b1;
                    end
                end
            end
            c_st_wr_xfer: begin
                if (w_wr_evt && (addr == 3'd0)) begin
                    if (r_ptr == c_ptr_last) begin
                        w_ptr_n   = '0;
                        w_state_n = c_st_wr_commit;
                        w_cnt_n   = c_busy_reload;
                    end else begin
                        w_ptr_n = r_ptr + 1'b1;
                    end
                end
            end
            default: w_state_n = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_rem     <= '0;
            r_lba_cur <= '0;
            r_irq     <= 1'b0;
            r_err     <= 1'b0;
            r_error   <= 8'h00;
            r_count   <= 8'h00;
            r_lba0    <= 8'h00;
            r_lba1    <= 8'h00;
            r_lba2    <= 8'h00;
            r_dev     <= 8'h00;
            r_rd_q    <= 1'b0;
            r_wr_q    <= 1'b0;
            r_rd_addr <= 3'd0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_ptr     <= w_ptr_n;
            r_rem     <= w_rem_n;
            r_lba_cur <= w_lba_cur_n;
            r_irq     <= w_irq_n;
            r_err     <= w_err_n;
            r_error   <= w_error_n;
            r_count   <= w_count_n;
            r_lba0    <= w_lba0_n;
            r_lba1    <= w_lba1_n;
            r_lba2    <= w_lba2_n;
            r_dev     <= w_dev_n;
            r_rd_q    <= w_rd_acc;
            r_wr_q    <= w_wr_acc;
            if (w_rd_acc) begin
                r_rd_addr <= addr;
            end
        end
    end

    // Disk contents and the sector buffer are deliberately outside reset.
    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            for (int b = 0; b < c_bpw; b++) begin
                r_sbuf[c_sb_w'(r_ptr * c_bpw + b)] <= data_in[b*8 +: 8];
            end
        end
        if (w_commit) begin
            for (int i = 0; i < SECTOR_BYTES; i++) begin
                r_mem[w_base + c_aw'(i)] <= r_sbuf[c_sb_w'(i)];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ata_disk_model.md
Name: ata_disk_model

Overview:
Parametrised behavioural ATA/IDE disk model for bench use. It implements the task-file register set, multi-sector READ/WRITE SECTORS with a BSY/DRQ handshake, LBA28 addressing and error reporting. It replaces the single-sector fixed-size drive model and sits on the CPU's IDE chip-select in the system testbench. Disk contents live in an internal array that survives reset.

Parameters:
- DATA_W, 8, data register width; 8 or 16 (16 = little-endian word transfers).
- SECTOR_BYTES, 512, bytes per sector; power of two.
- NUM_SECTORS, 2048, disk capacity in sectors.
- BUSY_CYCLES, 4, clocks of BSY before each sector's DRQ phase or commit; minimum 1.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous, active-high reset.
- cs_n  in  1  chip select, active low.
- rd_n  in  1  read strobe, active low.
- wr_n  in  1  write strobe, active low.
- addr  in  3  task-file register index.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data; 'z when not reading.
- irq  out  1  interrupt request, active high.
- busy  out  1  debug copy of status BSY.

Behaviour:
- Reset values: all task-file registers 0; status 8'h40 (DRDY); error 0; irq 0; busy 0; state IDLE; buffer pointer 0. Disk array is not cleared.
- Access types:
  - rd_acc = !cs_n & !rd_n & wr_n; wr_acc = !cs_n & !wr_n.
  - Writes are taken on the clk edge where wr_acc is high and was low the previous cycle (leading edge).
  - Data-register reads advance the pointer on the edge where rd_acc was high the previous cycle and is now low (trailing edge).
  - data_out = rd_acc ? selected register : 'z (combinational).
- Register map:
  - 0: data.
  - 1: error (R) / features (W, ignored).
  - 2: sector count; 0 means 256.
  - 3–5: LBA[7:0], [15:8], [23:16].
  - 6: bits [3:0] = LBA[27:24].
  - 7: status (R) / command (W).
  - Non-data registers use data bits [7:0]; upper bits read 0.
- Status bits: 7 BSY, 6 DRDY, 3 DRQ, 0 ERR. Error bits: 2 ABRT, 4 IDNF.
- Task-file writes while BSY=1 are ignored. Data-register accesses outside a DRQ phase are ignored; reads return 0.
- Command write in IDLE clears ERR, the error register and irq.
  - 8'h20: go to RD_BUSY.
  - 8'h30: go to WR_XFER immediately (DRQ=1, BSY=0).
  - 8'hE7 (flush): BSY for BUSY_CYCLES, then IDLE with irq=1.
  - Any other value: ERR=1, ABRT=1, irq=1, stay IDLE.
- Range check at command accept: if LBA + count > NUM_SECTORS, set ERR and IDNF, assert irq, stay IDLE, transfer nothing.
- States:
  - IDLE.
  - RD_BUSY: BSY for BUSY_CYCLES.
  - RD_XFER: DRQ=1, irq pulses high.
  - WR_XFER.
  - WR_COMMIT: BSY for BUSY_CYCLES.
- Sector transfer:
  - Words per sector W = SECTOR_BYTES/(DATA_W/8).
  - Pointer counts 0..W-1. Byte offset = (LBA_cur * SECTOR_BYTES) + pointer*(DATA_W/8).
  - In 16-bit mode, the low byte is at the lower address.
- RD_XFER: after W reads, decrement remaining count and increment LBA_cur.
  - If remaining > 0: go to RD_BUSY.
  - Else: IDLE, DRQ=0, DRDY=1.
  - Registers 3–6 are not updated by transfers.
- WR_XFER: words go into the sector buffer. After W writes, go to WR_COMMIT. At the end of BUSY, the buffer is copied to the disk array in one clock and irq is set.
  - If remaining > 0 after the copy: back to WR_XFER.
  - Else: IDLE.
- irq is cleared on a status-register read (trailing edge) or a command write. irq is set on the same edge as the event that raises it; set wins over a simultaneous clear.
- Reset mid-operation: the command aborts immediately and all outputs return to reset values. The disk array holds only sectors fully committed before reset; the partial sector buffer is discarded.

Test Plan:
- Preload disk bytes 0x000–0x3FF with addr[7:0]. Regs: count=2, LBA=0, cmd 8'h20. Expect BSY for 4 clk, DRQ, irq. Reads return 0x00..0xFF,0x00..0xFF for sector 0, then the same again after BSY for sector 1; final status 8'h40.
- Cmd 8'h30, count=1, LBA=5. Write 512 bytes 0xA5 ^ i. Expect DRQ drop, BSY 4 clk, then mem[2560+i] = 0xA5 ^ i and irq=1. A read-back via 8'h20 matches.
- DATA_W=16: read sector 0 preloaded with bytes 0x11,0x22. Expect first word 16'h2211 and exactly 256 words per sector.
- LBA=2047, count=2 -> status 8'h41, error 8'h10, irq=1, DRQ never set. Cmd 8'hFF -> error 8'h04.
- Assert arst after 100 bytes of a 2-sector write whose first sector has committed. Expect status 8'h40, irq 0, sector 0 written, sector 1 unchanged.
- Write LBA register while BSY=1 -> value unchanged. Read data register in IDLE -> 0, pointer not advanced.
